// File: rtl/fmt_pkg.sv
// Shared definitions for the formatted-text streamer: size defaults,
// the NUL padding character and the controller state encoding.
package fmt_pkg;

  localparam int NBYTES_DEFAULT = 20;
  localparam int FMT_W_DEFAULT  = 8 * NBYTES_DEFAULT;

  localparam logic [7:0] NUL_CHAR = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : fmt_pkg

// File: rtl/fmt_byte_sel.sv
// Combinational byte selector: returns byte idx of a packed multi-byte word,
// where byte 0 occupies bits [7:0].
module fmt_byte_sel
  import fmt_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT,
  parameter int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic [8*NBYTES-1:0] data,
  input  logic [IDX_W-1:0]    idx,
  output logic [7:0]          byte_out
);

  // Walk every slot and pick the one whose position matches idx.
  always_comb begin
    // NOTE: default assignment first so no path leaves byte_out unassigned (no latch).
    byte_out = NUL_CHAR;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        byte_out = data[i*8 +: 8];
      end
    end
  end

endmodule : fmt_byte_sel

// File: rtl/fmt_streamer.sv
// Formatted-text streamer: captures a right-justified, NUL-padded text word
// and emits its non-NUL characters first-to-last over a valid/ready port.
module fmt_streamer
  import fmt_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT,
  parameter int FMT_W  = 8 * NBYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [FMT_W-1:0] fmt_in,
  input  logic             load,
  input  logic             clear_ovr,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int              IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NBYTES - 1);

  state_t           state;
  logic [FMT_W-1:0] buf_q;
  logic [IDX_W-1:0] idx;
  logic [7:0]       cur_byte;

  fmt_byte_sel #(
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_byte_sel (
    .data     (buf_q),
    .idx      (idx),
    .byte_out (cur_byte)
  );

  // Sequencer: scan bytes from the first character downwards, hand each
  // non-NUL byte to the consumer, flag loads that arrive while not idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the text buffer is a plain register bank, so it is reset along with the control state.
      state      <= IDLE;
      idx        <= IDX_MAX;
      buf_q      <= '0;
      char_out   <= NUL_CHAR;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;

      // A rejected load sets the flag and takes priority over a clear.
      if (load && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clear_ovr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (load) begin
            buf_q <= fmt_in;
            idx   <= IDX_MAX;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (cur_byte != NUL_CHAR) begin
            char_out   <= cur_byte;
            char_valid <= 1'b1;
            state      <= SEND;
          end else if (idx != '0) begin
            idx <= idx - 1'b1;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        SEND: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            if (idx != '0) begin
              idx   <= idx - 1'b1;
              state <= SCAN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : fmt_streamer

// File: tb/tb_fmt_streamer.sv
// Self-checking bench for fmt_streamer: a character-queue scoreboard checks
// order, stability and done behaviour every cycle; directed runs check timing
// against arithmetic derived from the byte contents, pinned by literal values.
module tb_fmt_streamer;

  localparam int NB = 20;
  localparam int FW = 8 * NB;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] fmt_in;
  logic          load;
  logic          clear_ovr;
  logic [7:0]    char_out;
  logic          char_valid;
  logic          char_ready;
  logic          busy;
  logic          done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       prev_done = 1'b0;

  fmt_streamer #(.NBYTES(NB), .FMT_W(FW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fmt_in     (fmt_in),
    .load       (load),
    .clear_ovr  (clear_ovr),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance past one rising edge; inputs change and checks happen 2 units later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every presented character must be the next expected one,
  // held until accepted; done only when the string is exhausted, one cycle wide.
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (char_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra_char: got 0x%0h, expected no character at %0t", char_out, $time);
        end else begin
          check("sb_char", char_out, exp_q[0]);
          if (char_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        check("sb_done_queue_empty", exp_q.size(), 0);
        check("sb_done_single", prev_done, 0);
        check("sb_done_no_valid", char_valid, 0);
      end
      prev_done = done;
    end
  end

  // Non-NUL characters of a text word in emission order (first char at the top byte).
  task automatic model_chars(input logic [FW-1:0] f, output int nchars, output int lead);
    logic [7:0] b;
    bit seen;
    nchars = 0;
    lead   = 0;
    seen   = 1'b0;
    for (int i = NB - 1; i >= 0; i--) begin
      b = f[i*8 +: 8];
      if (b != 8'h00) begin
        exp_q.push_back(b);
        nchars++;
        seen = 1'b1;
      end else if (!seen) begin
        lead++;
      end
    end
  endtask

  // Load a string and stream it to completion. The consumer stalls stall_len
  // cycles on character number stall_char; an extra load (optionally with
  // clear_ovr) is driven for the edge after step reload_at.
  task automatic stream(input string tag, input logic [FW-1:0] f,
                        input int stall_char, input int stall_len,
                        input int reload_at, input bit reload_clr,
                        output int t_done, output int v0, output int v1, output int nv);
    int  nchars, lead, t, char_idx, stalled, exp_done;
    bit  prev_v;
    model_chars(f, nchars, lead);
    exp_done = NB + nchars + ((stall_char < nchars) ? stall_len : 0);
    fmt_in = f;
    load = 1'b1;
    char_ready = 1'b1;
    cyc();
    t = 0; t_done = -1; v0 = -1; v1 = -1; nv = 0;
    char_idx = 0; stalled = 0; prev_v = 1'b0;
    while (t < 300) begin
      if (char_valid && !prev_v) begin
        if (nv == 0) v0 = t;
        if (nv == 1) v1 = t;
        nv++;
      end
      prev_v = char_valid;
      if (done && t_done < 0) t_done = t;
      check({tag, "_busy"}, busy, 1);
      // Next-edge inputs.
      load      = (t == reload_at);
      clear_ovr = reload_clr && (t == reload_at);
      fmt_in    = (t == reload_at) ? FW'(160'h5A5A_5A5A) : f;
      char_ready = 1'b1;
      if (char_valid) begin
        if (char_idx == stall_char && stalled < stall_len) begin
          char_ready = 1'b0;
          stalled++;
        end else begin
          char_idx++;
        end
      end
      if (done) break;
      cyc();
      t++;
    end
    if (t_done < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: no done within 300 cycles", tag);
    end
    check({tag, "_done_edge"}, t_done, exp_done);
    check({tag, "_nvalid"}, nv, nchars);
    if (nchars > 0) check({tag, "_first_valid"}, v0, lead + 1);
    cyc();
    load = 1'b0;
    clear_ovr = 1'b0;
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    int td, v0, v1, nv;
    reset      = 1'b1;
    fmt_in     = '0;
    load       = 1'b0;
    clear_ovr  = 1'b0;
    char_ready = 1'b1;
    #12;
    check("rst_char_out", char_out, 8'h00);
    check("rst_valid", char_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;

    // "AB", always ready.
    stream("ab", FW'(160'h4142), 99, 0, -1, 1'b0, td, v0, v1, nv);
    check("ab_v0_lit", v0, 19);
    check("ab_v1_lit", v1, 21);
    check("ab_done_lit", td, 22);
    check("ab_last_char", char_out, 8'h42);
    check("ab_ovr_clean", overrun, 0);

    // "AB" with a 5-cycle stall on 'A'.
    stream("stall", FW'(160'h4142), 0, 5, -1, 1'b0, td, v0, v1, nv);
    check("stall_v0_lit", v0, 19);
    check("stall_v1_lit", v1, 26);
    check("stall_done_lit", td, 27);

    // All NUL: no characters, done after a full scan.
    stream("nul", '0, 99, 0, -1, 1'b0, td, v0, v1, nv);
    check("nul_nv_lit", nv, 0);
    check("nul_done_lit", td, 20);

    // Interior and trailing NULs skipped.
    stream("gap", FW'(160'h4100_4200), 99, 0, -1, 1'b0, td, v0, v1, nv);
    check("gap_v0_lit", v0, 17);
    check("gap_v1_lit", v1, 20);
    check("gap_done_lit", td, 22);

    // Load while scanning is rejected; stream unchanged, overrun set.
    stream("ovr", FW'(160'h4142), 99, 0, 3, 1'b0, td, v0, v1, nv);
    check("ovr_set", overrun, 1);
    clear_ovr = 1'b1;
    cyc();
    clear_ovr = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Rejected load coinciding with clear_ovr: set wins.
    stream("ovrclr", FW'(160'h4142), 99, 0, 5, 1'b1, td, v0, v1, nv);
    check("ovr_set_wins", overrun, 1);
    clear_ovr = 1'b1;
    cyc();
    clear_ovr = 1'b0;
    check("ovr_cleared2", overrun, 0);

    // Load landing in the DONE cycle is rejected too.
    stream("ovrdone", FW'(160'h4142), 99, 0, 22, 1'b0, td, v0, v1, nv);
    check("ovr_in_done", overrun, 1);

    // Reset in SEND aborts without done; a load right after release works.
    fmt_in = FW'(160'h4142);
    load = 1'b1;
    model_chars(fmt_in, nv, v0);
    cyc();
    load = 1'b0;
    repeat (19) cyc();
    check("rst_mid_valid_before", char_valid, 1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_valid", char_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_overrun", overrun, 0);
    check("rst_mid_char", char_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    stream("post", FW'(160'h43), 99, 0, -1, 1'b0, td, v0, v1, nv);
    check("post_v0_lit", v0, 20);
    check("post_char_lit", char_out, 8'h43);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_fmt_streamer

// File: doc/fmt_streamer.md
FMT_STREAMER -- requirements
Module: fmt_streamer

Interface
REQ-001 SHALL have parameter NBYTES, default 20, meaning the number of character slots in the formatted-text word.
REQ-002 SHALL have parameter FMT_W, default 8*NBYTES (160), meaning the width of the formatted-text word.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port fmt_in, input, FMT_W bits: formatted text; byte NBYTES-1 (bits 159:152) is the first character, and the text is right-justified with NUL (0x00) padding at the MSB end.
REQ-006 SHALL have port load, input, 1 bit: capture fmt_in and start streaming.
REQ-007 SHALL have port clear_ovr, input, 1 bit: clear the overrun flag.
REQ-008 SHALL have port char_out, output, 8 bits: the current character.
REQ-009 SHALL have port char_valid, output, 1 bit: char_out is valid.
REQ-010 SHALL have port char_ready, input, 1 bit: the consumer accepts char_out.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a string.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, set when a load is rejected.

Function
REQ-014 SHALL implement the states IDLE, SCAN, SEND and DONE, with a byte index idx ranging 0..NBYTES-1.
REQ-015 IDLE: when load=1, SHALL capture fmt_in into an internal buffer, set idx=NBYTES-1 and go to SCAN on the same edge.
REQ-016 SCAN: SHALL examine one byte per cycle, buf[idx].
REQ-017 SCAN: when buf[idx]=0x00 and idx>0, SHALL decrement idx; when buf[idx]=0x00 and idx=0, SHALL go to DONE.
REQ-018 SCAN: when buf[idx]≠0x00, SHALL register char_out=buf[idx], set char_valid=1 and go to SEND.
REQ-019 Every NUL byte SHALL be skipped, whether leading or interior; no NUL is ever presented on char_out.
REQ-020 SEND: char_out and char_valid SHALL remain stable until char_valid&&char_ready is sampled high.
REQ-021 SEND, on acceptance: SHALL set char_valid=0; if idx>0, SHALL decrement idx and go to SCAN; if idx=0, SHALL go to DONE.
REQ-022 DONE: done SHALL be 1 for exactly this one cycle, after which the block returns to IDLE.
REQ-023 A load in any state other than IDLE (including DONE) SHALL be ignored, leaving the buffer unchanged, and SHALL set overrun.
REQ-024 clear_ovr=1 SHALL clear overrun; if clear_ovr and a rejected load coincide, set SHALL win.
REQ-025 An all-NUL fmt_in SHALL scan NBYTES cycles, then pulse done without ever asserting char_valid.
REQ-026 Latency from the load edge to the first char_valid SHALL be (number of leading NULs + 1) cycles.
REQ-027 Each further character SHALL cost 1 SCAN cycle plus the SEND wait.
REQ-028 char_ready while char_valid=0 SHALL have no effect.
REQ-029 The index SHALL never wrap: idx=0 always terminates to DONE.

Reset
REQ-030 reset=1 SHALL immediately force: state=IDLE, idx=NBYTES-1, buffer=0, char_out=0x00, char_valid=0, busy=0, done=0, overrun=0.
REQ-031 A reset asserted mid-string SHALL abort the string with no done pulse; after release the block SHALL accept a new load in the first cycle.

Structure
REQ-032 Shared package fmt_pkg SHALL hold the NBYTES and FMT_W defaults, the NUL_CHAR constant (0x00) and the state enum {IDLE, SCAN, SEND, DONE}.
REQ-033 The combinational byte-select mux (buffer, idx → byte) SHALL be the sub-module fmt_byte_sel; everything else SHALL be in fmt_streamer.

Verification
REQ-034 SHALL cover: fmt_in=0x4142 (zero-extended "AB"), load at edge 0, char_ready=1 → char_valid high after edge 19 with 0x41, after edge 21 with 0x42, done after edge 22, busy low after edge 23.
REQ-035 SHALL cover: same string with char_ready=0 for 5 cycles during 'A' → char_out holds 0x41 with char_valid=1 for all 5 cycles, and 'B' follows exactly as in REQ-034, shifted by 5.
REQ-036 SHALL cover: all-NUL fmt_in, load → no char_valid ever, done pulses after edge 20.
REQ-037 SHALL cover: fmt_in=0x41004200 → only 0x41 then 0x42 emitted, interior and trailing NULs skipped, then done.
REQ-038 SHALL cover: second load while busy → output stream unchanged and overrun=1, then clear_ovr → overrun=0; load plus clear_ovr in the same cycle while busy → overrun=1.
REQ-039 SHALL cover: reset pulsed in SEND → char_valid=0, busy=0, no done, and a subsequent load streams correctly.
